// File: rtl/cart_to_sphere_radius_if.sv
// Request/result bundle for the Cartesian-to-radius converter.
interface cart_to_sphere_radius_if #(
    parameter int unsigned W = 16
);
    logic                en;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic signed [W-1:0] z_in;
    logic        [W-1:0] radius;
    logic                rdy;
    logic                busy;

    modport master (
        output en, x_in, y_in, z_in,
        input  radius, rdy, busy
    );

    modport slave (
        input  en, x_in, y_in, z_in,
        output radius, rdy, busy
    );
endinterface

// File: rtl/cart_to_sphere_radius.sv
// Multi-cycle r = floor(sqrt(x^2+y^2+z^2)): one shared squarer over three cycles,
// then a W-iteration non-restoring digit-by-digit square root (2 radicand bits/iter).
module cart_to_sphere_radius #(
    parameter int unsigned W = 16
) (
    input logic                      clk,
    input logic                      rst,
    cart_to_sphere_radius_if.slave   io_bus
);
    localparam int unsigned CntW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StSq, StRt} state_e;

    state_e              r_state, w_state_d;
    logic signed [W-1:0] r_x, r_y, r_z, w_x_d, w_y_d, w_z_d;
    logic [2*W-1:0]      r_acc, w_acc_d;
    logic [CntW-1:0]     r_cnt, w_cnt_d;
    logic [W+1:0]        r_rem, w_rem_d;
    logic [W-1:0]        r_root, w_root_d;
    logic [W-1:0]        r_radius, w_radius_d;
    logic                r_rdy, w_rdy_d;

    logic signed [W-1:0]   w_op;
    logic signed [2*W-1:0] w_op_ext;
    logic [2*W-1:0]        w_sq;
    logic [W+1:0]          w_rem_sh, w_qterm, w_rem_nx;
    logic [W-1:0]          w_root_nx;

    // Shared squarer: operand chosen by the SQ-phase counter (x, then y, then z).
    always_comb begin
        w_op = r_x;
        if (r_cnt == CntW'(1)) begin
            w_op = r_y;
        end else if (r_cnt == CntW'(2)) begin
            w_op = r_z;
        end
        w_op_ext = {{W{w_op[W-1]}}, w_op};
        w_sq     = w_op_ext * w_op_ext;
    end

    // One root iteration: acc doubles as radicand shift register, top 2 bits consumed.
    // Sign of the remainder picks subtract (4Q+1) or add (4Q+3).
    always_comb begin
        w_rem_sh  = {r_rem[W-1:0], r_acc[2*W-1 -: 2]};
        w_qterm   = {r_root, r_rem[W+1], 1'b1};
        w_rem_nx  = r_rem[W+1] ? (w_rem_sh + w_qterm) : (w_rem_sh - w_qterm);
        w_root_nx = {r_root[W-2:0], ~w_rem_nx[W+1]};
    end

    // Next-state and datapath updates.
    always_comb begin
        w_state_d  = r_state;
        w_x_d      = r_x;
        w_y_d      = r_y;
        w_z_d      = r_z;
        w_acc_d    = r_acc;
        w_cnt_d    = r_cnt;
        w_rem_d    = r_rem;
        w_root_d   = r_root;
        w_radius_d = r_radius;
        w_rdy_d    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.en) begin
                    w_x_d     = io_bus.x_in;
                    w_y_d     = io_bus.y_in;
                    w_z_d     = io_bus.z_in;
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
                    w_rem_d   = '0;
                    w_root_d  = '0;
                    w_state_d = StSq;
                end
            end
            StSq: begin
                w_acc_d = r_acc + w_sq;
                if (r_cnt == CntW'(2)) begin
                    w_cnt_d   = '0;
                    w_state_d = StRt;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StRt: begin
                w_rem_d  = w_rem_nx;
                w_root_d = w_root_nx;
                w_acc_d  = {r_acc[2*W-3:0], 2'b00};
                if (r_cnt == CntW'(W - 1)) begin
                    w_radius_d = w_root_nx;
                    w_rdy_d    = 1'b1;
                    w_cnt_d    = '0;
                    w_state_d  = StIdle;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_radius <= '0;
            r_rdy    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_x      <= w_x_d;
            r_y      <= w_y_d;
            r_z      <= w_z_d;
            r_acc    <= w_acc_d;
            r_cnt    <= w_cnt_d;
            r_rem    <= w_rem_d;
            r_root   <= w_root_d;
            r_radius <= w_radius_d;
            r_rdy    <= w_rdy_d;
        end
    end

    assign io_bus.radius = r_radius;
    assign io_bus.rdy    = r_rdy;
    assign io_bus.busy   = (r_state != StIdle);
endmodule
